// File: rtl/prediction_history_buffer_pkg.sv
// Shared prediction types for the in-flight prediction history buffer.
// INDEX_LEN is the width of a predictor table index.
package prediction_history_buffer_pkg;

  localparam int INDEX_LEN = 8;

  typedef struct packed {
    logic [INDEX_LEN-1:0] index;
    logic                 local_equal_global;
    logic                 had_guessed_global;
  } phb_entry_t;

endpackage

// File: rtl/prediction_history_match.sv
// Youngest-match selector: scans slots from head in allocation order and keeps
// the last match seen, which is the one allocated most recently.
module prediction_history_match #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  input  logic [PTR_W-1:0] head,
  output logic             hit,
  output logic [PTR_W-1:0] slot
);

  logic [PTR_W-1:0] age_slot [DEPTH];
  logic [DEPTH-1:0] age_match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W:0] sum;
      assign sum           = {1'b0, head} + (PTR_W+1)'(gi);
      assign age_slot[gi]  = (sum >= (PTR_W+1)'(DEPTH)) ? PTR_W'(sum - (PTR_W+1)'(DEPTH))
                                                         : sum[PTR_W-1:0];
      assign age_match[gi] = match[age_slot[gi]];
    end
  endgenerate

  always_comb begin
    hit  = 1'b0;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_match[i]) begin
        hit  = 1'b1;
        slot = age_slot[i];
      end
    end
  end

endmodule

// File: rtl/prediction_history_buffer.sv
// In-flight prediction buffer: circular queue of issued predictions with
// youngest-match query, in-order retirement, flush and sticky error reporting.
module prediction_history_buffer
  import prediction_history_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_stalling,
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [INDEX_LEN-1:0] push_index,
  input  logic                 push_local_equal_global,
  input  logic                 push_guessed_global,
  input  logic [INDEX_LEN-1:0] query_index,
  output logic                 query_hit,
  output logic                 query_had_guessed_global,
  output logic                 query_were_equal,
  output logic                 head_valid,
  output logic [INDEX_LEN-1:0] head_index,
  output logic                 head_had_guessed_global,
  output logic                 head_were_equal,
  input  logic                 retire,
  input  logic                 flush,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  phb_entry_t       entry_mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             error_reg;

  logic push_req, push_acc, push_err;
  logic retire_acc, retire_err;
  logic empty;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign push_ready = !full;
  assign count      = count_reg;
  assign error      = error_reg;

  // Stall suppresses the push entirely, so a stalled push while full is not an error.
  assign push_req   = push_valid && !is_stalling && !flush;
  assign push_acc   = push_req && !full;
  assign push_err   = push_req && full;
  assign retire_acc = retire && !empty && !flush;
  assign retire_err = retire && empty && !flush;

  always_ff @(posedge clk) begin
    if (push_acc) begin
      entry_mem[tail_reg] <= '{index: push_index,
                               local_equal_global: push_local_equal_global,
                               had_guessed_global: push_guessed_global};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      if (push_err || retire_err) error_reg <= 1'b1;
      if (flush) begin
        valid_reg <= '0;
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (retire_acc) begin
          valid_reg[head_reg] <= 1'b0;
          head_reg            <= ptr_inc(head_reg);
        end
        if (push_acc) begin
          valid_reg[tail_reg] <= 1'b1;
          tail_reg            <= ptr_inc(tail_reg);
        end
        if (push_acc && !retire_acc)      count_reg <= count_reg + CNT_W'(1);
        else if (retire_acc && !push_acc) count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  logic [DEPTH-1:0] match_vec;
  logic             sel_hit;
  logic [PTR_W-1:0] sel_slot;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match_vec[gi] = valid_reg[gi] && (entry_mem[gi].index == query_index);
    end
  endgenerate

  prediction_history_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .match (match_vec),
    .head  (head_reg),
    .hit   (sel_hit),
    .slot  (sel_slot)
  );

  phb_entry_t sel_entry;
  phb_entry_t head_entry;

  assign sel_entry                = entry_mem[sel_slot];
  assign query_hit                = sel_hit;
  assign query_had_guessed_global = sel_hit && sel_entry.had_guessed_global;
  assign query_were_equal         = sel_hit && sel_entry.local_equal_global;

  assign head_entry              = entry_mem[head_reg];
  assign head_valid              = !empty;
  assign head_index              = empty ? '0 : head_entry.index;
  assign head_had_guessed_global = !empty && head_entry.had_guessed_global;
  assign head_were_equal         = !empty && head_entry.local_equal_global;

endmodule

// File: doc/prediction_history_buffer.md
# prediction_history_buffer

Parametrised in-flight prediction buffer for the tournament branch predictor. It records, per issued prediction, the table index, whether the local and global components agreed, and which component was chosen. The chooser-update logic queries it by index; the youngest matching entry wins. Entries retire in order at branch resolution and are discarded wholesale on a pipeline flush. Successor to the fixed-length shift-queue history: adds depth parametrisation, valid tracking, in-order retirement, flush, occupancy, back-pressure and error reporting.

## Interface
- DEPTH, 8, number of entries; any value ≥ 2 (not limited to powers of two)
- CNT_W, $clog2(DEPTH+1), width of the occupancy count
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- is_stalling  in  1  pipeline stall; while high, pushes are suppressed
- push_valid  in  1  record a new prediction
- push_ready  out  1  buffer can accept a push; equals !full
- push_index  in  INDEX_LEN  predictor table index
- push_local_equal_global  in  1  local and global predictions agreed
- push_guessed_global  in  1  chooser selected the global prediction
- query_index  in  INDEX_LEN  lookup key
- query_hit  out  1  at least one valid entry matches query_index
- query_had_guessed_global  out  1  chooser selection of the youngest matching entry; 0 when there is no hit
- query_were_equal  out  1  agreement flag of the youngest matching entry; 0 when there is no hit
- head_valid  out  1  buffer is non-empty
- head_index, head_had_guessed_global, head_were_equal  out  INDEX_LEN/1/1  fields of the oldest entry; all 0 when empty
- retire  in  1  pop the oldest entry
- flush  in  1  invalidate all entries
- count  out  CNT_W  number of valid entries
- full  out  1  count == DEPTH
- error  out  1  sticky; set on a retire while empty or a push while full; cleared only by reset

## Operation
- Circular buffer with head and tail pointers in 0..DEPTH-1; each pointer wraps from DEPTH-1 to 0.
- Push accepted when push_valid && !is_stalling && !full && !flush. The entry is written at tail, tail advances, and count increments.
- Retire accepted when retire && count != 0 && !flush. The head entry is invalidated, head advances, and count decrements.
- Simultaneous accepted push and retire: count is unchanged and both pointers advance.
- Push while full: the push is dropped and error is set. This includes the case where a retire occurs in the same cycle.
- Retire while empty: the retire is ignored and error is set.
- Flush has priority over everything else. All valid bits clear, head = tail = 0, count = 0. A push or retire in the same cycle is discarded and sets no error.
- Query, purely combinational:
  - Compare query_index against every valid entry.
  - Select the youngest match, i.e. the one nearest tail-1 in allocation order, regardless of physical slot.
  - With no match, all three query outputs are 0.
- Query and head outputs reflect registered contents only. A push in the current cycle is not visible until the next cycle.
- is_stalling does not gate retire, flush or query.

## Timing
- Reset values:
  - count = 0, full = 0, push_ready = 1, head_valid = 0, error = 0.
  - Query and head outputs are 0.
  - Pointers are 0 and all valid bits are 0.
- A push or retire in cycle N is reflected in count, full, head_* and query_* from cycle N+1.
- Query-to-output path: combinational, zero latency.
- push_ready depends only on registered state; there is no combinational path from any input.
- Reset asserted mid-operation clears state asynchronously. The first push after reset deasserts may occur on the next rising edge.

## Structure
- The shared prediction package provides INDEX_LEN and the entry typedef: packed struct of index, local_equal_global, had_guessed_global.
- Valid bits are held separately from the entry array.
- One sub-module is natural: prediction_history_match, a combinational youngest-match priority selector.
  - Inputs: per-entry match vector and head pointer.
  - Outputs: hit flag and selected slot.

## Test plan
- Reset, then 3 pushes of (index, equal, guessed) = (5,1,0), (9,0,1), (5,0,1) -> count = 3. Query 5 returns hit = 1, guessed = 1, equal = 0 (youngest wins). Query 9 returns hit = 1, guessed = 1, equal = 0. Query 7 returns hit = 0 and all outputs 0.
- DEPTH = 4:
  - Push 4 entries -> full = 1, push_ready = 0.
  - A 5th push is dropped and error = 1.
  - Retire twice, push twice -> tail wraps; head_index equals the 3rd original entry.
- Retire on empty -> count stays 0 and error = 1. Only reset clears error.
- Push and retire in the same cycle at count = 2 -> count stays 2 and the head advances by one.
- is_stalling = 1 with push_valid = 1 for 3 cycles -> count unchanged. A retire in the same window still decrements count.
- Flush with 3 entries, together with push_valid and retire -> next cycle count = 0, head_valid = 0, no query hits, error unchanged.
